// File: rtl/dip_serializer.sv
// Serialises a 16-bit DIP word and a 5-bit switch word MSB first, then
// raises a one-cycle latch strobe and waits out an idle gap.
module dip_serializer #(
  parameter int unsigned GAP_CYCLES  = 2,
  parameter bit          AUTO_REPEAT = 1'b0
) (
  input  logic        i_CLK,
  input  logic        i_RESET,
  input  logic [15:0] i_DIP16,
  input  logic [4:0]  i_Switch5,
  input  logic        i_Valid,
  output logic        o_Ready,
  output logic        o_Data,
  output logic        o_Latch,
  output logic        o_Busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH,
    ST_GAP
  } state_e;

  localparam logic [4:0] LAST_BIT = 5'd20;
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [20:0] frame_q, frame_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic        captured_q, captured_d;
  logic        data_q, data_d;
  logic        latch_q, latch_d;

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    captured_d = captured_q;
    data_d     = 1'b0;
    latch_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // The first bit is registered on the capture edge so it appears one clock later.
        if (i_Valid) begin
          frame_d    = {i_DIP16, i_Switch5};
          bit_cnt_d  = '0;
          data_d     = i_DIP16[15];
          captured_d = 1'b1;
          state_d    = ST_SHIFT;
        end else if (AUTO_REPEAT && captured_q) begin
          bit_cnt_d = '0;
          data_d    = frame_q[20];
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
          latch_d = 1'b1;
          state_d = ST_LATCH;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          data_d    = frame_q[5'd19 - bit_cnt_q];
        end
      end
      ST_LATCH: begin
        if (GAP_CYCLES == 0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      captured_q <= 1'b0;
      data_q     <= 1'b0;
      latch_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      captured_q <= captured_d;
      data_q     <= data_d;
      latch_q    <= latch_d;
    end
  end

  assign o_Ready = (state_q == ST_IDLE);
  assign o_Busy  = (state_q != ST_IDLE);
  assign o_Data  = data_q;
  assign o_Latch = latch_q;

endmodule
